// File: rtl/rename_map_table_if.sv
// Rename-stage bundle: decode handshake, dispatch handshake, free-list and branch-resolution ports.
// The slave modport is the rename map table; master is the surrounding pipeline.
interface rename_map_table_if #(
  parameter int PHYS_REGS  = 128,
  parameter int CKPT_DEPTH = 4
);
  localparam int PB = $clog2(PHYS_REGS);
  localparam int CB = $clog2(CKPT_DEPTH);

  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [4:0]    in_rd;
  logic          in_rd_wen;
  logic          in_is_branch;

  logic          out_valid;
  logic          out_ready;
  logic [PB-1:0] out_prs1;
  logic [PB-1:0] out_prs2;
  logic [PB-1:0] out_prd;
  logic [PB-1:0] out_old_prd;
  logic [CB-1:0] out_ckpt_id;
  logic          out_is_branch;

  logic          fl_alloc_en;
  logic [PB-1:0] fl_alloc_preg;
  logic          fl_empty;
  logic [PB-1:0] fl_checkpoint_ptr;
  logic          fl_restore_en;
  logic [PB-1:0] fl_restore_ptr;

  logic          br_resolve_valid;
  logic [CB-1:0] br_resolve_id;
  logic          br_mispredict;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_is_branch,
    output in_ready,
    output out_valid, out_prs1, out_prs2, out_prd, out_old_prd, out_ckpt_id, out_is_branch,
    input  out_ready,
    output fl_alloc_en, fl_restore_en, fl_restore_ptr,
    input  fl_alloc_preg, fl_empty, fl_checkpoint_ptr,
    input  br_resolve_valid, br_resolve_id, br_mispredict
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_is_branch,
    input  in_ready,
    input  out_valid, out_prs1, out_prs2, out_prd, out_old_prd, out_ckpt_id, out_is_branch,
    output out_ready,
    input  fl_alloc_en, fl_restore_en, fl_restore_ptr,
    output fl_alloc_preg, fl_empty, fl_checkpoint_ptr,
    output br_resolve_valid, br_resolve_id, br_mispredict
  );
endinterface

// File: rtl/rename_map_table.sv
// Register rename map table with CKPT_DEPTH branch checkpoints for single-cycle mispredict recovery.
// Optional RENAME_PERF_CNT_EN adds perf_renamed / perf_stall_fl / perf_stall_ckpt counters.
module rename_map_table #(
  parameter int ARCH_REGS  = 32,
  parameter int PHYS_REGS  = 128,
  parameter int CKPT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  rename_map_table_if.slave bus
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]      perf_renamed,
  output logic [31:0]      perf_stall_fl,
  output logic [31:0]      perf_stall_ckpt
`endif
);
  localparam int PB = $clog2(PHYS_REGS);
  localparam int CB = $clog2(CKPT_DEPTH);

  logic [PB-1:0] rat      [ARCH_REGS];
  logic [PB-1:0] rat_next [ARCH_REGS];
  logic [PB-1:0] snap     [CKPT_DEPTH][ARCH_REGS];
  logic [PB-1:0] ckpt_fl_ptr [CKPT_DEPTH];

  logic [CB-1:0] head;
  logic [CB-1:0] tail;
  logic [CB:0]   count;

  logic          need_rd;
  logic          ckpt_full;
  logic          mispredict_req;
  logic [CB-1:0] resolve_dist;
  logic          id_live;
  logic          do_restore;
  logic          do_retire;
  logic          fire;
  logic          take_ckpt;
  logic [PB-1:0] ckpt_ptr_adj;
  logic [PB-1:0] prs1_lookup;
  logic [PB-1:0] prs2_lookup;

  assign need_rd        = bus.in_rd_wen && (bus.in_rd != 5'd0);
  assign ckpt_full      = (count == (CB+1)'(CKPT_DEPTH));
  assign mispredict_req = bus.br_resolve_valid && bus.br_mispredict;

  // A checkpoint id is live when its distance from head is inside the occupied window.
  assign resolve_dist = bus.br_resolve_id - head;
  assign id_live      = ({1'b0, resolve_dist} < count);
  assign do_restore   = mispredict_req && id_live && !rst;
  assign do_retire    = bus.br_resolve_valid && !bus.br_mispredict &&
                        (bus.br_resolve_id == head) && (count != '0) && !rst;

  assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !(need_rd && bus.fl_empty) &&
                        !(bus.in_is_branch && ckpt_full) && !mispredict_req;
  assign fire         = bus.in_valid && bus.in_ready && !rst;
  assign take_ckpt    = fire && bus.in_is_branch;

  assign bus.fl_alloc_en    = fire && need_rd;
  assign bus.fl_restore_en  = do_restore;
  assign bus.fl_restore_ptr = do_restore ? ckpt_fl_ptr[bus.br_resolve_id] : '0;

  // The snapshot must point past this instruction's own pop, wrapping at PHYS_REGS.
  assign ckpt_ptr_adj = (need_rd && (bus.fl_checkpoint_ptr == PB'(PHYS_REGS - 1))) ? '0 :
                        bus.fl_checkpoint_ptr + PB'(need_rd);

  assign prs1_lookup = (bus.in_rs1 == 5'd0) ? '0 : rat[bus.in_rs1];
  assign prs2_lookup = (bus.in_rs2 == 5'd0) ? '0 : rat[bus.in_rs2];

  // Map as it will look after this cycle's rd write; feeds both the RAT and a new checkpoint.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      rat_next[i] = rat[i];
    end
    if (bus.fl_alloc_en) begin
      rat_next[bus.in_rd] = bus.fl_alloc_preg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= PB'(i);
      end
    end else if (do_restore) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= snap[bus.br_resolve_id][i];
      end
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= rat_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take_ckpt) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        snap[tail][i] <= rat_next[i];
      end
      ckpt_fl_ptr[tail] <= ckpt_ptr_adj;
    end
  end

  // A mispredict discards the resolved checkpoint and everything younger than it.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (do_restore) begin
      tail  <= bus.br_resolve_id;
      count <= {1'b0, resolve_dist};
    end else begin
      if (take_ckpt) begin
        tail <= tail + 1'b1;
      end
      if (do_retire) begin
        head <= head + 1'b1;
      end
      if (take_ckpt && !do_retire) begin
        count <= count + 1'b1;
      end else if (!take_ckpt && do_retire) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_prs1      <= '0;
      bus.out_prs2      <= '0;
      bus.out_prd       <= '0;
      bus.out_old_prd   <= '0;
      bus.out_ckpt_id   <= '0;
      bus.out_is_branch <= 1'b0;
    end else if (do_restore) begin
      bus.out_valid <= 1'b0;
    end else if (fire) begin
      bus.out_valid     <= 1'b1;
      bus.out_prs1      <= prs1_lookup;
      bus.out_prs2      <= prs2_lookup;
      bus.out_prd       <= need_rd ? bus.fl_alloc_preg : '0;
      bus.out_old_prd   <= rat[bus.in_rd];
      bus.out_ckpt_id   <= tail;
      bus.out_is_branch <= bus.in_is_branch;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef RENAME_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_renamed    <= '0;
      perf_stall_fl   <= '0;
      perf_stall_ckpt <= '0;
    end else begin
      if (fire) begin
        perf_renamed <= perf_renamed + 32'd1;
      end
      if (bus.in_valid && need_rd && bus.fl_empty) begin
        perf_stall_fl <= perf_stall_fl + 32'd1;
      end
      if (bus.in_valid && bus.in_is_branch && ckpt_full) begin
        perf_stall_ckpt <= perf_stall_ckpt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table; a tiny free-list model hands out sequential tags from 32.
module tb_rename_map_table;
  logic clk;
  logic rst;
  logic [6:0] fl_head;
  int checks;
  int failures;

  rename_map_table_if #(.PHYS_REGS(128), .CKPT_DEPTH(4)) bus ();

  rename_map_table #(.ARCH_REGS(32), .PHYS_REGS(128), .CKPT_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free list behaves as a ring whose tag equals its head pointer.
  assign bus.fl_alloc_preg     = fl_head;
  assign bus.fl_checkpoint_ptr = fl_head;
  always @(posedge clk) begin
    if (rst) fl_head <= 7'd32;
    else if (bus.fl_restore_en) fl_head <= bus.fl_restore_ptr;
    else if (bus.fl_alloc_en) fl_head <= fl_head + 7'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic wen, input logic br);
    bus.in_valid     = v;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_rd        = rd;
    bus.in_rd_wen    = wen;
    bus.in_is_branch = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectRename(input string tag, input int p1, input int p2, input int pd, input int old);
    checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, ".prs1"}, 32'(bus.out_prs1), 32'(p1));
    checkOutput({tag, ".prs2"}, 32'(bus.out_prs2), 32'(p2));
    checkOutput({tag, ".prd"}, 32'(bus.out_prd), 32'(pd));
    checkOutput({tag, ".old_prd"}, 32'(bus.out_old_prd), 32'(old));
  endtask

  task automatic resolve(input logic v, input logic [1:0] id, input logic mis);
    bus.br_resolve_valid = v;
    bus.br_resolve_id    = id;
    bus.br_mispredict    = mis;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    resolve(1'b0, 2'd0, 1'b0);
    bus.out_ready = 1'b1;
    bus.fl_empty  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset.out_prd", 32'(bus.out_prd), 32'd0);
    checkOutput("reset.out_prs1", 32'(bus.out_prs1), 32'd0);
    checkOutput("reset.fl_alloc_en", 32'(bus.fl_alloc_en), 32'd0);
    checkOutput("reset.fl_restore_en", 32'(bus.fl_restore_en), 32'd0);
    checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);

    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    #1 checkOutput("add3.fl_alloc_en", 32'(bus.fl_alloc_en), 32'd1);
    tick(); expectRename("add3", 1, 2, 32, 3);
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
    tick(); expectRename("raw3", 32, 0, 33, 4);
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0);
    tick(); expectRename("add5", 5, 5, 34, 5);
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    tick(); expectRename("raw5", 34, 0, 35, 6);
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
    #1 checkOutput("rdx0.fl_alloc_en", 32'(bus.fl_alloc_en), 32'd0);
    tick(); expectRename("rdx0", 1, 2, 0, 0);

    bus.fl_empty = 1'b1;
    applyStimulus(1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 1'b0);
    #1 checkOutput("flempty.in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("flempty.fl_alloc_en", 32'(bus.fl_alloc_en), 32'd0);
    tick(); checkOutput("flempty.out_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, 5'd1, 5'd1, 5'd7, 1'b0, 1'b0);
    #1 checkOutput("flempty.nowrite_ready", 32'(bus.in_ready), 32'd1);
    tick(); expectRename("nowrite", 1, 1, 0, 7);
    bus.fl_empty = 1'b0;
    applyStimulus(1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 1'b0);
    tick(); expectRename("add7", 1, 1, 36, 7);

    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 5'd1, 5'd1, 5'd8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("stall.in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("stall.fl_alloc_en", 32'(bus.fl_alloc_en), 32'd0);
      tick(); expectRename("stall.hold", 1, 1, 36, 7);
    end
    bus.out_ready = 1'b1;
    tick(); expectRename("add8", 1, 1, 37, 8);

    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("br.ckpt_id", 32'(bus.out_ckpt_id), 32'(i));
      checkOutput("br.is_branch", 32'(bus.out_is_branch), 32'd1);
    end
    #1 checkOutput("full.in_ready", 32'(bus.in_ready), 32'd0);
    resolve(1'b1, 2'd0, 1'b0);
    #1 checkOutput("full.resolve_ready", 32'(bus.in_ready), 32'd0);
    tick(); resolve(1'b0, 2'd0, 1'b0);
    #1 checkOutput("freed.in_ready", 32'(bus.in_ready), 32'd1);
    tick(); checkOutput("br5.ckpt_id", 32'(bus.out_ckpt_id), 32'd0);
    resolve(1'b1, 2'd3, 1'b0);
    tick(); resolve(1'b0, 2'd0, 1'b0);
    #1 checkOutput("wrongid.in_ready", 32'(bus.in_ready), 32'd0);
    resolve(1'b1, 2'd1, 1'b0);
    tick(); resolve(1'b1, 2'd2, 1'b0);
    #1 checkOutput("fire_resolve.in_ready", 32'(bus.in_ready), 32'd1);
    tick(); resolve(1'b0, 2'd0, 1'b0);
    checkOutput("fire_resolve.ckpt_id", 32'(bus.out_ckpt_id), 32'd1);
    #1 checkOutput("cnt3.in_ready", 32'(bus.in_ready), 32'd1);
    tick(); checkOutput("br7.ckpt_id", 32'(bus.out_ckpt_id), 32'd2);
    #1 checkOutput("refull.in_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, 5'd1, 5'd1, 5'd9, 1'b1, 1'b0);
    #1 checkOutput("full.nonbranch_ready", 32'(bus.in_ready), 32'd1);
    tick(); expectRename("add9", 1, 1, 38, 9);

    applyStimulus(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
    rst = 1'b1;
    #1 checkOutput("midrst.fl_alloc_en", 32'(bus.fl_alloc_en), 32'd0);
    tick(); rst = 1'b0;
    checkOutput("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, 5'd10, 5'd3, 5'd10, 1'b1, 1'b0);
    tick(); expectRename("postrst", 10, 3, 32, 10);

    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick(); checkOutput("mp.br0", 32'(bus.out_ckpt_id), 32'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 5'd1, 5'd0, 5'(11 + i), 1'b1, 1'b0);
      tick(); checkOutput("mp.alloc_prd", 32'(bus.out_prd), 32'(33 + i));
    end
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick(); checkOutput("mp.br1", 32'(bus.out_ckpt_id), 32'd1);
    applyStimulus(1'b1, 5'd1, 5'd1, 5'd10, 1'b1, 1'b0);
    tick(); expectRename("young10", 1, 1, 40, 32);
    applyStimulus(1'b1, 5'd1, 5'd1, 5'd11, 1'b1, 1'b0);
    tick(); expectRename("young11", 1, 1, 41, 33);
    applyStimulus(1'b1, 5'd1, 5'd1, 5'd20, 1'b1, 1'b0);
    tick(); expectRename("young20", 1, 1, 42, 20);

    resolve(1'b1, 2'd1, 1'b1);
    applyStimulus(1'b1, 5'd1, 5'd1, 5'd21, 1'b1, 1'b0);
    #1 checkOutput("mp.restore_en", 32'(bus.fl_restore_en), 32'd1);
    checkOutput("mp.restore_ptr", 32'(bus.fl_restore_ptr), 32'd40);
    checkOutput("mp.in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("mp.fl_alloc_en", 32'(bus.fl_alloc_en), 32'd0);
    tick(); resolve(1'b0, 2'd0, 1'b0);
    checkOutput("mp.out_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, 5'd10, 5'd11, 5'd21, 1'b1, 1'b0);
    tick(); expectRename("mp.snap", 32, 33, 40, 21);
    applyStimulus(1'b1, 5'd20, 5'd0, 5'd22, 1'b1, 1'b0);
    tick(); expectRename("mp.x20", 20, 0, 41, 22);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick(); checkOutput("mp.tail", 32'(bus.out_ckpt_id), 32'd1);

    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    resolve(1'b1, 2'd3, 1'b1);
    #1 checkOutput("deadid.restore_en", 32'(bus.fl_restore_en), 32'd0);
    tick(); resolve(1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick(); checkOutput("deadid.next_id", 32'(bus.out_ckpt_id), 32'd2);

    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(); checkOutput("hold.out_valid", 32'(bus.out_valid), 32'd1);
    resolve(1'b1, 2'd0, 1'b1);
    #1 checkOutput("stallmp.restore_ptr", 32'(bus.fl_restore_ptr), 32'd33);
    tick(); resolve(1'b0, 2'd0, 1'b0);
    checkOutput("stallmp.out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 5'd11, 5'd10, 5'd12, 1'b1, 1'b0);
    tick(); expectRename("stallmp.after", 11, 32, 33, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
